// File: rtl/fetcher.sv
// Instruction fetch stage feeding decode.
//
// Issues one 32-bit read at a time to the memory controller, predicts the next PC
// statically from the returned instruction, and buffers {inst, pc, taken} in a
// circular instruction queue. The queue head is always presented to decode and is
// consumed on the same edge that decode samples it. A ROB rollback flushes the
// queue, redirects the PC and throws away any response still in flight.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   out_mem_req/addr       registered read request to memory (held until response)
//   in_mem_ready/inst      single-cycle response pulse with the fetched word
//   in_stall               downstream back-pressure
//   out_issue_ena          head entry consumed this cycle (drives decode ena)
//   out_inst/pc/predicted_taken   queue head contents (don't-care when empty)
//   in_rollback/_pc        mispredict flush and corrected PC
module fetcher #(
    parameter int unsigned IQ_DEPTH = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        out_mem_req,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ready,
    input  logic [31:0] in_mem_inst,
    input  logic        in_stall,
    output logic        out_issue_ena,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_predicted_taken,
    input  logic        in_rollback,
    input  logic [31:0] in_rollback_pc
);

    localparam int unsigned PtrW = $clog2(IQ_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(IQ_DEPTH);
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

    state_e state_q, state_d;

    logic [31:0]     pc_q, pc_d;
    logic            mem_req_q, mem_req_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0]         iq_inst_q [IQ_DEPTH];
    logic [31:0]         iq_pc_q   [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] iq_taken_q;

    logic        launch, push, pop;
    logic [31:0] j_imm, b_imm;
    logic        pred_taken;
    logic [31:0] pred_next;

    // Static prediction: JAL and backward branches are taken, everything else falls through.
    assign j_imm = {{12{in_mem_inst[31]}}, in_mem_inst[19:12], in_mem_inst[20],
                    in_mem_inst[30:21], 1'b0};
    assign b_imm = {{20{in_mem_inst[31]}}, in_mem_inst[7], in_mem_inst[30:25],
                    in_mem_inst[11:8], 1'b0};

    always_comb begin
        pred_taken = 1'b0;
        pred_next  = pc_q + 32'd4;
        if (in_mem_inst[6:0] == OpJal) begin
            pred_taken = 1'b1;
            pred_next  = pc_q + j_imm;
        end else if (in_mem_inst[6:0] == OpBranch && in_mem_inst[31]) begin
            pred_taken = 1'b1;
            pred_next  = pc_q + b_imm;
        end
    end

    // A request is only launched with a free slot, so the eventual push cannot overflow.
    assign launch = (state_q == StIdle) && !in_rollback && (count_q < CntFull);
    assign push   = (state_q == StWait) && in_mem_ready && !in_rollback;
    assign pop    = out_issue_ena;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (launch) state_d = StWait;
            end
            StWait: begin
                if (in_mem_ready)     state_d = StIdle;
                else if (in_rollback) state_d = StDiscard;
            end
            StDiscard: begin
                // The stale response still has to be absorbed before a new request.
                if (in_mem_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                end
            end
            StWait, StDiscard: begin
                if (in_mem_ready) mem_req_d = 1'b0;
            end
            default: mem_req_d = 1'b0;
        endcase
        out_issue_ena = (count_q != '0) && !in_stall && !in_rollback;
    end

    // Queue pointers and fetch PC
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (in_rollback) begin
            pc_d    = in_rollback_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pred_next;
                tail_d = tail_q + PtrW'(1);
            end
            if (pop) head_d = head_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage needs no reset; only entries between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            iq_inst_q[tail_q]  <= in_mem_inst;
            iq_pc_q[tail_q]    <= pc_q;
            iq_taken_q[tail_q] <= pred_taken;
        end
    end

    assign out_mem_req         = mem_req_q;
    assign out_mem_addr        = mem_addr_q;
    assign out_inst            = iq_inst_q[head_q];
    assign out_pc              = iq_pc_q[head_q];
    assign out_predicted_taken = iq_taken_q[head_q];

endmodule
